// File: rtl/dbus_ctrl.sv
// Data-bus access controller: issues one memory-stage access to the dbus,
// holds it until the dbus completes it, and reports the result to the pipeline.
module dbus_ctrl #(
  parameter logic [15:0] MAX_LAT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  input  logic        flush,
  output logic        d_valid,
  output logic [63:0] d_addr,
  output logic [2:0]  d_size,
  output logic [7:0]  d_strobe,
  output logic [63:0] d_data,
  input  logic        d_data_ok,
  input  logic [63:0] d_rdata,
  output logic [63:0] rdata,
  output logic        done,
  output logic        busy,
  output logic [15:0] last_lat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        complete;
  logic [15:0] lat_cnt;
  logic [15:0] lat_inc;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          state_nxt = BUSY;
          accept    = 1'b1;
        end
      end
      BUSY: begin
        if (d_data_ok) begin
          // A flush in the completing cycle discards the result silently.
          state_nxt = flush ? IDLE : DONE;
          complete  = !flush;
        end else if (flush) begin
          state_nxt = ABORT;
        end
      end
      DONE:  state_nxt = IDLE;
      // The dbus request cannot be withdrawn, so wait it out and drop the data.
      ABORT: if (d_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // d_valid is decoded from state so an asynchronous reset drops it at once.
  assign d_valid = (state == BUSY) || (state == ABORT);
  assign done    = (state == DONE) && !flush;
  assign busy    = reset &&
                   (((state == IDLE) && req_valid && !flush) || (state == BUSY) || (state == ABORT));
  assign lat_inc = (lat_cnt == MAX_LAT) ? lat_cnt : lat_cnt + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      d_addr   <= '0;
      d_size   <= '0;
      d_strobe <= '0;
      d_data   <= '0;
      rdata    <= '0;
      lat_cnt  <= '0;
      last_lat <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        d_addr   <= req_addr;
        d_size   <= req_size;
        d_strobe <= req_strobe;
        d_data   <= req_data;
        lat_cnt  <= '0;
      end else if (d_valid) begin
        lat_cnt <= lat_inc;
      end
      // The completing cycle itself counts toward the reported latency.
      if (complete) begin
        rdata    <= d_rdata;
        last_lat <= lat_inc;
      end
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl: transaction-level model of each access
// (wait length, flush point) predicts every cycle's bus and pipeline outputs.
module tb_dbus_ctrl;

  localparam logic [15:0] TB_MAX_LAT = 16'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        flush;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_data;
  logic        d_data_ok;
  logic [63:0] d_rdata;
  logic [63:0] rdata;
  logic        done;
  logic        busy;
  logic [15:0] last_lat;

  int n_vec = 0;
  int n_err = 0;

  // Model of the result registers, updated only by completed, unsquashed accesses.
  logic [63:0] m_rdata;
  logic [15:0] m_last_lat;

  dbus_ctrl #(.MAX_LAT(TB_MAX_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_strobe (req_strobe),
    .req_data   (req_data),
    .flush      (flush),
    .d_valid    (d_valid),
    .d_addr     (d_addr),
    .d_size     (d_size),
    .d_strobe   (d_strobe),
    .d_data     (d_data),
    .d_data_ok  (d_data_ok),
    .d_rdata    (d_rdata),
    .rdata      (rdata),
    .done       (done),
    .busy       (busy),
    .last_lat   (last_lat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // One complete access starting from IDLE at cycle start (posedge+1).
  // wait_n: d_data_ok arrives in the wait_n-th d_valid cycle.
  // flush_at: d_valid cycle in which flush is raised (0 = never).
  task automatic run_access(input logic [63:0] addr, input logic [2:0] size,
                            input logic [7:0] strobe, input logic [63:0] data,
                            input logic [63:0] rd, input int wait_n, input int flush_at,
                            input logic hold_req, input logic flush_done, input string name);
    bit          aborted;
    logic        exp_done;
    aborted = (flush_at >= 1) && (flush_at <= wait_n);

    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = size;
    req_strobe = strobe;
    req_data   = data;
    flush      = 1'b0;
    d_data_ok  = 1'($urandom_range(0, 1));
    d_rdata    = {$urandom, $urandom};
    @(negedge clk);
    n_vec++;
    if ({busy, d_valid, done} !== 3'b100) begin
      n_err++;
      $display("FAIL %s issue: busy,d_valid,done=%b want 100", name, {busy, d_valid, done});
    end
    @(posedge clk); #1;

    for (int k = 1; k <= wait_n; k++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = {$urandom, $urandom};
      req_size   = 3'($urandom);
      req_strobe = 8'($urandom);
      req_data   = {$urandom, $urandom};
      if (k < flush_at || flush_at == 0)  flush = 1'b0;
      else if (k == flush_at)             flush = 1'b1;
      else                                flush = 1'($urandom_range(0, 1));
      d_data_ok = (k == wait_n);
      d_rdata   = (k == wait_n) ? rd : {$urandom, $urandom};
      @(negedge clk);
      n_vec++;
      if ({d_valid, d_addr, d_size, d_strobe, d_data, busy, done} !==
          {1'b1, addr, size, strobe, data, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL %s bus cycle %0d: d_valid=%b addr=%h size=%h strobe=%h data=%h busy=%b done=%b; want 1 %h %h %h %h 1 0",
                 name, k, d_valid, d_addr, d_size, d_strobe, d_data, busy, done,
                 addr, size, strobe, data);
      end
      @(posedge clk); #1;
    end

    req_valid = hold_req && !aborted;
    flush     = flush_done;
    d_data_ok = 1'($urandom_range(0, 1));
    d_rdata   = {$urandom, $urandom};
    if (!aborted) begin
      m_rdata    = rd;
      m_last_lat = (wait_n > int'(TB_MAX_LAT)) ? TB_MAX_LAT : 16'(wait_n);
    end
    exp_done = !aborted && !flush_done;
    @(negedge clk);
    n_vec++;
    if ({d_valid, busy, done, rdata, last_lat} !== {1'b0, 1'b0, exp_done, m_rdata, m_last_lat}) begin
      n_err++;
      $display("FAIL %s finish: d_valid=%b busy=%b done=%b rdata=%h last_lat=%0d; want 0 0 %b %h %0d",
               name, d_valid, busy, done, rdata, last_lat, exp_done, m_rdata, m_last_lat);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    d_data_ok = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    n_vec++;
    if ({busy, d_valid, d_addr, d_size, d_strobe, d_data, rdata, done, last_lat} !== '0) begin
      n_err++;
      $display("FAIL %s: busy=%b d_valid=%b addr=%h size=%h strobe=%h data=%h rdata=%h done=%b last_lat=%0d; want all 0",
               name, busy, d_valid, d_addr, d_size, d_strobe, d_data, rdata, done, last_lat);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = {$urandom, $urandom};
    req_size   = 3'd3;
    req_strobe = 8'hFF;
    req_data   = {$urandom, $urandom};
    flush      = 1'b0;
    d_data_ok  = 1'b1;
    d_rdata    = {$urandom, $urandom};
    m_rdata    = '0;
    m_last_lat = '0;
    #3;
    check_all_zero("reset_start");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    reset     = 1'b1;
    req_valid = 1'b0;
    d_data_ok = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    run_access(64'h80001000, 3'd3, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D, 1, 0, 1'b0, 1'b0, "read_zero_wait");
  endtask

  task automatic test_write_wait3();
    run_access(64'h80002008, 3'd2, 8'h0F, 64'h11223344, {$urandom, $urandom}, 3, 0, 1'b0, 1'b0, "write_wait3");
  endtask

  task automatic test_flush_mid();
    run_access(64'h80003000, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 4, 2, 1'b0, 1'b0, "flush_mid");
    run_access(64'h80003040, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 2, 2, 1'b0, 1'b0, "flush_on_ok");
  endtask

  task automatic test_flush_idle();
    req_valid = 1'b1;
    flush     = 1'b1;
    req_addr  = {$urandom, $urandom};
    d_data_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, d_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_idle same cycle: busy,d_valid=%b want 00", {busy, d_valid});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    d_data_ok = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, d_valid, done} !== 3'b000) begin
      n_err++;
      $display("FAIL flush_idle after: busy,d_valid,done=%b want 000", {busy, d_valid, done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_access(64'h80004000, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 1, 0, 1'b1, 1'b0, "b2b_first");
    run_access(64'h80004008, 3'd3, 8'hFF, {$urandom, $urandom}, {$urandom, $urandom}, 2, 0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_done_flush();
    run_access(64'h80005000, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 2, 0, 1'b0, 1'b1, "done_flushed");
  endtask

  task automatic test_saturation();
    run_access(64'h80006000, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 4, 0, 1'b0, 1'b0, "lat_below_max");
    run_access(64'h80006008, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 5, 0, 1'b0, 1'b0, "lat_at_max");
    run_access(64'h80006010, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 9, 0, 1'b0, 1'b0, "lat_saturated");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int w;
      int f;
      w = $urandom_range(1, 8);
      f = ($urandom_range(0, 2) == 0) ? $urandom_range(1, w + 2) : 0;
      run_access({$urandom, $urandom}, 3'($urandom), 8'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, w, f, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  task automatic test_reset_mid_busy();
    req_valid  = 1'b1;
    req_addr   = 64'h80007000;
    req_size   = 3'd3;
    req_strobe = 8'hFF;
    req_data   = {$urandom, $urandom};
    flush      = 1'b0;
    d_data_ok  = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    n_vec++;
    if (d_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy pre: d_valid=%b want 1", d_valid);
    end
    reset      = 1'b0;
    m_rdata    = '0;
    m_last_lat = '0;
    #1;
    check_all_zero("reset_mid_busy_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_mid_busy_held");
    reset = 1'b1;
    run_access(64'h80008000, 3'd3, 8'h00, 64'h0, {$urandom, $urandom}, 1, 0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_flush_mid();
    test_flush_idle();
    test_back_to_back();
    test_done_flush();
    test_saturation();
    test_random();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_ctrl.md
DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 Parameter MAX_LAT, default 16'hFFFF, saturation value of the latency counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 req_valid  input  1  memory stage requests a data access (already gated by misalignment and invalidate).
REQ-005 req_addr  input  64  access address.
REQ-006 req_size  input  3  msize_t encoding of the access width.
REQ-007 req_strobe  input  8  byte write enables; all zero means a read.
REQ-008 req_data  input  64  write data, already lane-aligned.
REQ-009 flush  input  1  squash the instruction currently in the memory stage.
REQ-010 d_valid / d_addr / d_size / d_strobe / d_data  output  1/64/3/8/64  request to the dbus.
REQ-011 d_data_ok  input  1  dbus completes the access this cycle.
REQ-012 d_rdata  input  64  dbus read data, valid when d_data_ok=1.
REQ-013 rdata  output  64  latched read data for the completed access.
REQ-014 done  output  1  one-cycle pulse: access finished and not squashed.
REQ-015 busy  output  1  stall request to the pipeline.
REQ-016 last_lat  output  16  number of cycles d_valid was high for the last completed access.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DONE and ABORT.
REQ-018 IDLE: if req_valid=1 and flush=0, latch req_addr, req_size, req_strobe and req_data; next state BUSY. Otherwise stay in IDLE.
REQ-019 d_valid SHALL be 1 only in BUSY and ABORT, driving the latched request, held stable until d_data_ok.
REQ-020 BUSY with d_data_ok=1 and flush=0: latch d_rdata into rdata; next state DONE.
REQ-021 BUSY with flush=1 and d_data_ok=0: next state ABORT.
REQ-022 BUSY with flush=1 and d_data_ok=1: next state IDLE; rdata is not updated and no done pulse occurs.
REQ-023 ABORT SHALL keep d_valid asserted, because the dbus request is never withdrawn. On d_data_ok=1 it goes to IDLE without updating rdata or pulsing done. flush has no effect in ABORT.
REQ-024 DONE SHALL last exactly one cycle and ignore req_valid; next state IDLE.
REQ-025 done = (state==DONE) and not flush.
REQ-026 busy = (IDLE and req_valid and not flush) or BUSY or ABORT. busy SHALL be 0 in DONE so the pipeline advances.
REQ-027 Minimum latency: req_valid sampled in cycle N, d_valid high in N+1; if d_data_ok is in N+1, done is high in N+2.
REQ-028 Latency counter: cleared on entry to BUSY, incremented each cycle d_valid=1, saturating at MAX_LAT with no wrap.
REQ-029 last_lat SHALL be loaded from the counter (including the completing cycle) only on the BUSY-to-DONE transition.
REQ-030 Any d_data_ok seen in IDLE or DONE SHALL be ignored.

Reset
REQ-031 When reset=0: state IDLE, d_valid=0, d_addr/d_size/d_strobe/d_data=0, rdata=0, done=0, last_lat=0, counter=0.
REQ-032 busy SHALL be 0 during reset regardless of req_valid.
REQ-033 Reset asserted mid-access (BUSY or ABORT) SHALL drop d_valid asynchronously. There is no completion and no done pulse.
REQ-034 After reset deasserts, the first req_valid SHALL be accepted on the next rising edge.

Verification
REQ-035 Read, zero wait:
- Stimulus: req_valid=1, addr=64'h80001000, strobe=0, d_data_ok=1 with d_rdata=64'hDEADBEEF_CAFEF00D in the first d_valid cycle.
- Response: done pulses one cycle later; rdata=64'hDEADBEEF_CAFEF00D; last_lat=1; busy low in the DONE cycle.
REQ-036 Write, three-cycle wait:
- Stimulus: strobe=8'h0F, data=64'h11223344; d_data_ok in the 3rd d_valid cycle.
- Response: d_* stable for all 3 cycles; done pulses once; last_lat=3.
REQ-037 Flush mid-access:
- Stimulus: flush=1 in the 2nd BUSY cycle; d_data_ok arrives 2 cycles later.
- Response: d_valid stays high through ABORT until d_data_ok; done never pulses; rdata unchanged; busy=1 until IDLE.
REQ-038 Flush with request in IDLE:
- Stimulus: req_valid=1 and flush=1 in the same cycle.
- Response: no access issued; d_valid=0; busy=0.
REQ-039 Back-to-back accesses:
- Stimulus: req_valid held high across the DONE cycle.
- Response: no second access is issued for the same instruction in DONE; the next access starts only from IDLE.
REQ-040 Reset mid-BUSY:
- Stimulus: reset=0 for 2 cycles.
- Response: all outputs 0 immediately; FSM returns to IDLE; a new request is accepted after release.
